// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout,
// 2-bit counter encodings and saturating counter arithmetic.
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    // Tag is held at full width here; the array stores only the live TAG_W bits.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: two combinational read ports (fetch, EX),
// one synchronous write port, one synchronous invalidate port, reset clear.
module btb_array
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 3,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_a_idx_i,
    output btb_entry_t       rd_a_o,
    input  logic [IDX_W-1:0] rd_b_idx_i,
    output btb_entry_t       rd_b_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  btb_entry_t       wr_entry_i,
    input  logic             inv_en_i,
    input  logic [IDX_W-1:0] inv_idx_i
);

    logic [ENTRIES-1:0]             valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][31:0]       target_q;
    logic [ENTRIES-1:0][1:0]        ctr_q;

    // Upper tag bits of the shared struct are always zero by construction.
    logic unused_tag_hi;
    assign unused_tag_hi = ^wr_entry_i.tag[31:TAG_W];

    function automatic btb_entry_t read_entry(input logic [IDX_W-1:0] i);
        btb_entry_t r;
        r                  = '0;
        r.valid            = valid_q[i];
        r.tag[TAG_W-1:0]   = tag_q[i];
        r.target           = target_q[i];
        r.ctr              = ctr_q[i];
        return r;
    endfunction

    assign rd_a_o = read_entry(rd_a_idx_i);
    assign rd_b_o = read_entry(rd_b_idx_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            if (wr_en_i) begin
                valid_q[wr_idx_i]  <= wr_entry_i.valid;
                tag_q[wr_idx_i]    <= wr_entry_i.tag[TAG_W-1:0];
                target_q[wr_idx_i] <= wr_entry_i.target;
                ctr_q[wr_idx_i]    <= wr_entry_i.ctr;
            end
            if (inv_en_i) begin
                valid_q[inv_idx_i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: BTB lookup at fetch, outcome resolution, redirect,
// table training and branch/mispredict statistics at EX.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_jalr_sel,
    input  logic             ex_branch_cond,
    input  logic [31:0]      ex_alu_result,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic [31:0]      pc_plus_4,
    output logic [31:0]      pc_plus_imm,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [PC_W-1:0]  if_tag_full, ex_tag_full;
    btb_entry_t       if_ent, ex_ent, wr_entry;
    logic             if_hit, ex_hit, wr_en, inv_en;
    logic             ctrl, actual_taken;
    logic [31:0]      ex_pc_ext, actual_target;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign ex_idx      = ex_pc[IDX_W+1:2];
    assign if_tag_full = if_pc >> (IDX_W + 2);
    assign ex_tag_full = ex_pc >> (IDX_W + 2);

    btb_array #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .rd_a_idx_i (if_idx),
        .rd_a_o     (if_ent),
        .rd_b_idx_i (ex_idx),
        .rd_b_o     (ex_ent),
        .wr_en_i    (wr_en),
        .wr_idx_i   (ex_idx),
        .wr_entry_i (wr_entry),
        .inv_en_i   (inv_en),
        .inv_idx_i  (ex_idx)
    );

    assign if_hit      = if_ent.valid && (if_ent.tag == 32'(if_tag_full));
    assign pred_taken  = if_hit && (if_ent.ctr >= CTR_WT);
    assign pred_target = if_hit ? if_ent.target : 32'd0;

    assign ex_pc_ext     = 32'(ex_pc);
    assign pc_plus_4     = ex_pc_ext + 32'd4;
    assign pc_plus_imm   = ex_pc_ext + ex_imm;
    assign ctrl          = ex_is_branch | ex_is_jal | ex_jalr_sel;
    assign actual_taken  = ex_is_jal | ex_jalr_sel | (ex_is_branch & ex_branch_cond);
    assign actual_target = ex_jalr_sel ? (ex_alu_result & ~32'd1) : pc_plus_imm;

    assign redirect    = ex_valid && ((ex_pred_taken != actual_taken) ||
                                      (actual_taken && (ex_pred_target != actual_target)));
    assign redirect_pc = actual_taken ? actual_target : pc_plus_4;

    assign ex_hit = ex_ent.valid && (ex_ent.tag == 32'(ex_tag_full));

    always_comb begin
        wr_en    = 1'b0;
        inv_en   = 1'b0;
        wr_entry = ex_ent;
        if (ex_valid) begin
            if (ctrl) begin
                if (ex_hit) begin
                    wr_en        = 1'b1;
                    wr_entry.ctr = actual_taken ? sat_inc(ex_ent.ctr) : sat_dec(ex_ent.ctr);
                    if (actual_taken) begin
                        wr_entry.target = actual_target;
                    end
                end else if (actual_taken) begin
                    // Allocation overwrites whatever victim occupies the slot.
                    wr_en           = 1'b1;
                    wr_entry.valid  = 1'b1;
                    wr_entry.tag    = 32'(ex_tag_full);
                    wr_entry.target = actual_target;
                    wr_entry.ctr    = (ex_is_jal | ex_jalr_sel) ? CTR_ST : CTR_WT;
                end
            end else if (ex_hit) begin
                inv_en = 1'b1;
            end
        end
    end

    assign branch_cnt_d     = branch_cnt_q + CNT_W'(ex_valid && ctrl);
    assign mispredict_cnt_d = mispredict_cnt_q + CNT_W'(redirect);

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule
